// File: rtl/config_valid_delay_line.sv
// Multi-lane stallable delay line with a shared valid, run-time delay select,
// flush and an in-flight counter. A delay of zero is a combinational bypass.
// Stages beyond the active delay keep shifting but are never observed.

// Range checker: the in-flight count can never exceed the active delay.
module config_valid_delay_line_chk #(
   parameter int DW = 4
) (
   input logic          clk,
   input logic          rst_n,
   input logic [DW-1:0] cur_delay,
   input logic [DW-1:0] in_flight
);

   // in_flight is bounded by the active window depth
   a_in_flight_le_delay : assert property (@(posedge clk) disable iff (!rst_n)
      in_flight <= cur_delay);

endmodule

module config_valid_delay_line #(
   parameter  int WIDTH         = 32,
   parameter  int LANES         = 1,
   parameter  int MAX_DELAY     = 8,
   parameter  int DEFAULT_DELAY = 1,
   localparam int DW            = $clog2(MAX_DELAY + 1),
   localparam int DATA_W        = LANES * WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              flush,
   input  logic              cfg_load,
   input  logic [DW-1:0]     cfg_delay,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [DW-1:0]     cur_delay,
   output logic [DW-1:0]     in_flight,
   output logic              busy
);

   logic [MAX_DELAY-1:0]             vld_q, vld_d;
   logic [MAX_DELAY-1:0][DATA_W-1:0] dat_q, dat_d;
   logic [DW-1:0]                    delay_q, delay_d;
   logic [DW-1:0]                    cnt_q, cnt_d;

   logic              tap_valid_s;
   logic [DATA_W-1:0] tap_data_s;
   logic              active_s;
   logic              enter_s;
   logic              exit_s;
   logic [DW-1:0]     cfg_sat_s;

   // Select stage[delay-1] as an AND-OR mux; no match (delay 0) yields zero
   always_comb begin
      tap_valid_s = 1'b0;
      tap_data_s  = '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
         tap_valid_s = tap_valid_s | (vld_q[i] & (delay_q == DW'(i + 1)));
         tap_data_s  = tap_data_s | (dat_q[i] & {DATA_W{delay_q == DW'(i + 1)}});
      end
   end

   // Window bookkeeping: what enters and leaves the observed window this cycle
   always_comb begin
      active_s  = (delay_q != {DW{1'b0}});
      enter_s   = in_valid & active_s;
      exit_s    = tap_valid_s & active_s;
      cfg_sat_s = (cfg_delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : cfg_delay;
   end

   // Next-state: cfg_load > flush > en > hold
   always_comb begin
      vld_d   = vld_q;
      dat_d   = dat_q;
      delay_d = delay_q;
      cnt_d   = cnt_q;
      if (cfg_load || flush) begin
         vld_d = '0;
         dat_d = '0;
         cnt_d = '0;
         if (cfg_load) begin
            delay_d = cfg_sat_s;
         end else begin
            delay_d = delay_q;
         end
      end else if (en) begin
         vld_d[0] = in_valid;
         dat_d[0] = in_valid ? in_data : {DATA_W{1'b0}};
         for (int i = 1; i < MAX_DELAY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         cnt_d = cnt_q + DW'(enter_s) - DW'(exit_s);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q   <= '0;
         dat_q   <= '0;
         delay_q <= DW'(DEFAULT_DELAY);
         cnt_q   <= '0;
      end else begin
         vld_q   <= vld_d;
         dat_q   <= dat_d;
         delay_q <= delay_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output tap: bypass at delay 0, otherwise the registered stage
   always_comb begin
      if (active_s) begin
         out_valid = tap_valid_s;
         out_data  = tap_data_s;
      end else begin
         out_valid = in_valid;
         out_data  = in_data;
      end
      cur_delay = delay_q;
      in_flight = cnt_q;
      busy      = (cnt_q != {DW{1'b0}});
   end

   config_valid_delay_line_chk #(.DW(DW)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .cur_delay (delay_q),
      .in_flight (cnt_q)
   );

endmodule
